// File: rtl/bsg_chip_pkg.sv
// bsg_chip_pkg: shared chip-level wormhole header layout and link-arbiter state encoding.
package bsg_chip_pkg;

    localparam int ct_width_gp      = 64;
    localparam int wh_cord_width_gp = 7;
    localparam int wh_len_width_gp  = 4;

    typedef struct packed {
        logic [ct_width_gp-wh_cord_width_gp-wh_len_width_gp-1:0] payload;
        logic [wh_len_width_gp-1:0]                              len;
        logic [wh_cord_width_gp-1:0]                             cord;
    } wh_header_s;

    typedef enum logic {e_idle, e_locked} wh_state_e;

endpackage

// File: rtl/bsg_chip_wh_link_concentrator_if.sv
// bsg_chip_wh_link_concentrator_if: N ready-and input links, one merged output link and packet stats.
interface bsg_chip_wh_link_concentrator_if #(
    parameter int flit_width_p = 64,
    parameter int num_in_p     = 2
);

    logic [num_in_p-1:0]              in_v;
    logic [num_in_p*flit_width_p-1:0] in_data;
    logic [num_in_p-1:0]              in_ready_and;
    logic                             out_v;
    logic [flit_width_p-1:0]          out_data;
    logic                             out_ready_and;
    logic [num_in_p*32-1:0]           stats;

    modport master (output in_v, in_data, out_ready_and, input in_ready_and, out_v, out_data, stats);
    modport slave  (input in_v, in_data, out_ready_and, output in_ready_and, out_v, out_data, stats);

endinterface

// File: rtl/bsg_chip_wh_lock_arbiter.sv
// bsg_chip_wh_lock_arbiter: round-robin grant held for a whole wormhole packet, plus completed-packet
// counters built only when BSG_CHIP_WH_CONCENTRATOR_STATS_EN is defined.
module bsg_chip_wh_lock_arbiter
    import bsg_chip_pkg::*;
#(
    parameter  int num_in_p    = 2,
    parameter  int len_width_p = 4,
    localparam int lg_lp       = $clog2(num_in_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_in_p-1:0]             head_v,
    input  logic [num_in_p*len_width_p-1:0] head_len,
    input  logic                            space,
    output logic [num_in_p-1:0]             yumi,
    output logic [lg_lp-1:0]                grant,
    output logic                            move,
    output logic [num_in_p*32-1:0]          stats
);

    wh_state_e              state, state_n;
    logic [lg_lp-1:0]       owner, owner_n, rr_ptr, rr_n, sel;
    logic [len_width_p-1:0] cnt, cnt_n, len;
    logic                   sel_v, done;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state  <= e_idle;
            owner  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            cnt    <= cnt_n;
            rr_ptr <= rr_n;
        end

    // Scan from the farthest offset down so the input nearest rr_ptr is the last, winning, match.
    always_comb begin
        sel_v = 1'b0;
        sel   = rr_ptr;
        for (int k = num_in_p - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr_ptr) + k) % num_in_p;
            if (head_v[j]) begin
                sel_v = 1'b1;
                sel   = lg_lp'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        cnt_n   = cnt;
        rr_n    = rr_ptr;
        if (move) begin
            if (state == e_idle && len != '0) begin
                state_n = e_locked;
                owner_n = grant;
                cnt_n   = len;
            end
            if (state == e_locked) cnt_n = cnt - len_width_p'(1);
            if (done) begin
                state_n = e_idle;
                rr_n    = (int'(grant) == num_in_p - 1) ? '0 : grant + lg_lp'(1);
            end
        end
    end

    always_comb begin
        grant = (state == e_locked) ? owner : sel;
        len   = head_len[int'(grant)*len_width_p +: len_width_p];
        move  = space & ((state == e_locked) ? head_v[grant] : sel_v);
        done  = move & ((state == e_locked) ? cnt == len_width_p'(1) : len == '0);
        yumi  = move ? num_in_p'(1) << grant : '0;
    end

`ifdef BSG_CHIP_WH_CONCENTRATOR_STATS_EN
    logic [num_in_p-1:0][31:0] stats_r;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) stats_r <= '0;
        else if (done && stats_r[grant] != '1) stats_r[grant] <= stats_r[grant] + 32'd1;

    assign stats = stats_r;
`else
    assign stats = '0;
`endif

endmodule

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: 2-entry ready-and/yumi FIFO; ready is a registered not-full, held low during reset.
module bsg_two_fifo #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem [2];
    logic               rd_ptr, wr_ptr, enq, deq;
    logic [1:0]         cnt, cnt_n;

    assign enq    = v_i & ready_o;
    assign deq    = yumi_i & v_o;
    assign cnt_n  = cnt + 2'(enq) - 2'(deq);
    assign v_o    = cnt != 2'd0;
    assign data_o = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            cnt     <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            ready_o <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            rd_ptr  <= rd_ptr ^ deq;
            wr_ptr  <= wr_ptr ^ enq;
            ready_o <= cnt_n != 2'd2;
        end

    always_ff @(posedge clk_i)
        if (enq) mem[wr_ptr] <= data_i;

endmodule

// File: rtl/bsg_chip_wh_link_concentrator.sv
// bsg_chip_wh_link_concentrator: merges wormhole ready-and links onto one link without interleaving packets.
// Per-input packet counters on stats appear only when BSG_CHIP_WH_CONCENTRATOR_STATS_EN is defined.
module bsg_chip_wh_link_concentrator #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    parameter int num_in_p     = 2
) (
    input logic                              clk_i,
    input logic                              reset_n_i,
    bsg_chip_wh_link_concentrator_if.slave   link
);

    localparam int lg_lp = $clog2(num_in_p);

    logic [flit_width_p-1:0]         head_data [num_in_p];
    logic [num_in_p-1:0]             head_v, yumi;
    logic [num_in_p*len_width_p-1:0] head_len;
    logic [lg_lp-1:0]                grant;
    logic                            move, space, ofifo_v, ofifo_yumi, out_v_r;
    logic [flit_width_p-1:0]         ofifo_data, out_data_r;

    for (genvar i = 0; i < num_in_p; i++) begin : g_in
        bsg_two_fifo #(.width_p(flit_width_p)) fifo (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .v_i       (link.in_v[i]),
            .data_i    (link.in_data[i*flit_width_p +: flit_width_p]),
            .ready_o   (link.in_ready_and[i]),
            .v_o       (head_v[i]),
            .data_o    (head_data[i]),
            .yumi_i    (yumi[i])
        );
        assign head_len[i*len_width_p +: len_width_p] = head_data[i][cord_width_p +: len_width_p];
    end

    bsg_chip_wh_lock_arbiter #(.num_in_p(num_in_p), .len_width_p(len_width_p)) arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .head_v    (head_v),
        .head_len  (head_len),
        .space     (space),
        .yumi      (yumi),
        .grant     (grant),
        .move      (move),
        .stats     (link.stats)
    );

    bsg_two_fifo #(.width_p(flit_width_p)) ofifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (move),
        .data_i    (head_data[grant]),
        .ready_o   (space),
        .v_o       (ofifo_v),
        .data_o    (ofifo_data),
        .yumi_i    (ofifo_yumi)
    );

    // Output register keeps out_data off the FIFO read mux and holds it while stalled.
    assign ofifo_yumi = ofifo_v & (~out_v_r | link.out_ready_and);

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) out_v_r <= 1'b0;
        else if (~out_v_r | link.out_ready_and) out_v_r <= ofifo_v;

    always_ff @(posedge clk_i)
        if (ofifo_yumi) out_data_r <= ofifo_data;

    assign link.out_v    = out_v_r;
    assign link.out_data = out_data_r;

endmodule

// File: tb/tb_bsg_chip_wh_link_concentrator.sv
// tb_bsg_chip_wh_link_concentrator: directed packets against hand-computed flit order, latency and stats.
module tb_bsg_chip_wh_link_concentrator;
    import bsg_chip_pkg::*;

    localparam int fw = 64;
`ifdef BSG_CHIP_WH_CONCENTRATOR_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_chip_wh_link_concentrator_if #(.flit_width_p(fw), .num_in_p(2)) link ();
    bsg_chip_wh_link_concentrator dut (.clk_i(clk), .reset_n_i(reset_n), .link(link));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rb = 0;
    int fb = 0;
    logic [fw-1:0] txq [2][$];
    int dlyq [2][$];
    logic fire [2];
    logic rand_rdy = 1'b0;
    logic stall_prev = 1'b0;
    logic [fw-1:0] stall_data;
    logic [fw-1:0] rx_data [$];
    int rx_cyc [$];
    int fire_cyc [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs are driven and outputs sampled on the falling edge; a handshake seen here completes on the next rise.
    always @(negedge clk) begin
        if (!reset_n) begin
            link.in_v = '0;
            link.in_data = '0;
            link.out_ready_and = 1'b1;
            fire[0] = 1'b0;
            fire[1] = 1'b0;
            stall_prev = 1'b0;
        end else begin
            link.out_ready_and = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (fire[i]) begin
                    void'(txq[i].pop_front());
                    void'(dlyq[i].pop_front());
                end
                fire[i] = 1'b0;
                link.in_v[i] = 1'b0;
                if (txq[i].size() > 0) begin
                    if (dlyq[i][0] > 0) dlyq[i][0] = dlyq[i][0] - 1;
                    else begin
                        link.in_v[i] = 1'b1;
                        link.in_data[i*fw +: fw] = txq[i][0];
                        fire[i] = link.in_ready_and[i];
                        if (fire[i]) fire_cyc.push_back(cyc);
                    end
                end
            end
            if (stall_prev) begin
                check("hold_v", link.out_v, 1);
                check("hold_data", link.out_data, stall_data);
            end
            if (link.out_v && link.out_ready_and) begin
                rx_data.push_back(link.out_data);
                rx_cyc.push_back(cyc);
            end
            stall_prev = link.out_v && !link.out_ready_and;
            stall_data = link.out_data;
        end
    end

    function automatic logic [63:0] hdr(input int len, input int tag);
        wh_header_s h;
        h.cord = 7'h5;
        h.len = 4'(len);
        h.payload = 53'(tag);
        return h;
    endfunction

    function automatic logic [63:0] rx(input int k);
        return (rb + k < rx_data.size()) ? rx_data[rb + k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic int rxc(input int k);
        return (rb + k < rx_cyc.size()) ? rx_cyc[rb + k] : -100;
    endfunction

    function automatic int ffc(input int k);
        return (fb + k < fire_cyc.size()) ? fire_cyc[fb + k] : -1000;
    endfunction

    task automatic send(input int i, input logic [63:0] d, input int dly = 0);
        txq[i].push_back(d);
        dlyq[i].push_back(dly);
    endtask

    task automatic mark();
        rb = rx_data.size();
        fb = fire_cyc.size();
    endtask

    task automatic wait_rx(input int n, input string tag);
        int k;
        k = 0;
        while (rx_data.size() < rb + n && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (6) @(negedge clk);
        #1;
        check(tag, rx_data.size() - rb, n);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            txq[i].delete();
            dlyq[i].delete();
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_v", link.out_v, 0);
        check("rst_in_rdy", link.in_ready_and, 0);
        reset_n = 1'b1;
        #1 check("rdy_before_edge", link.in_ready_and, 0);
        @(posedge clk);
        #1 check("rdy_after_edge", link.in_ready_and, 2'b11);
        check("idle_out_v", link.out_v, 0);

        // single len-3 packet: latency and back-to-back rate
        mark();
        send(0, hdr(3, 'h100));
        send(0, 64'hB1);
        send(0, 64'hB2);
        send(0, 64'hB3);
        wait_rx(4, "t1_cnt");
        check("t1_hdr", rx(0), hdr(3, 'h100));
        check("t1_b1", rx(1), 64'hB1);
        check("t1_b2", rx(2), 64'hB2);
        check("t1_b3", rx(3), 64'hB3);
        check("t1_lat", rxc(0), ffc(0) + 3);
        check("t1_rate", rxc(3), rxc(0) + 3);
        check("t1_stats0", link.stats[31:0], stats_en ? 64'd1 : 64'd0);

        // simultaneous len-2 headers, then len-0 pair showing the pointer returned to 0
        apply_reset();
        mark();
        send(0, hdr(2, 'h200));
        send(0, 64'hA201);
        send(0, 64'hA202);
        send(0, hdr(0, 'h210));
        send(1, hdr(2, 'h300));
        send(1, 64'hA301);
        send(1, 64'hA302);
        send(1, hdr(0, 'h310));
        wait_rx(8, "t2_cnt");
        check("t2_0", rx(0), hdr(2, 'h200));
        check("t2_1", rx(1), 64'hA201);
        check("t2_2", rx(2), 64'hA202);
        check("t2_3", rx(3), hdr(2, 'h300));
        check("t2_4", rx(4), 64'hA301);
        check("t2_5", rx(5), 64'hA302);
        check("t2_6", rx(6), hdr(0, 'h210));
        check("t2_7", rx(7), hdr(0, 'h310));

        // owner body withheld 5 cycles while input 1 waits
        mark();
        send(0, hdr(3, 'h400));
        send(0, 64'hC401);
        send(0, 64'hC402, 5);
        send(0, 64'hC403);
        send(1, hdr(0, 'h500));
        wait_rx(5, "t3_cnt");
        check("t3_0", rx(0), hdr(3, 'h400));
        check("t3_1", rx(1), 64'hC401);
        check("t3_2", rx(2), 64'hC402);
        check("t3_3", rx(3), 64'hC403);
        check("t3_4", rx(4), hdr(0, 'h500));
        check("t3_gap", rxc(2) - rxc(1) > 5, 1);

        // random downstream backpressure, 20 len-0 packets per input
        mark();
        rand_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send(0, hdr(0, 'h600 + k));
            send(1, hdr(0, 'h700 + k));
        end
        wait_rx(40, "t4_cnt");
        rand_rdy = 1'b0;
        for (int k = 0; k < 40; k++)
            check($sformatf("t4_%0d", k), rx(k), hdr(0, ((k % 2) ? 'h700 : 'h600) + k / 2));

        // reset in the middle of a len-4 packet
        mark();
        send(0, hdr(4, 'h800));
        send(0, 64'hD801);
        send(0, 64'hD802, 20);
        send(0, 64'hD803);
        send(0, 64'hD804);
        begin
            int k;
            k = 0;
            while (rx_data.size() < rb + 1 && k < 100) begin
                @(negedge clk);
                #1;
                k++;
            end
        end
        check("t5_pre_v", link.out_v, 1);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            txq[i].delete();
            dlyq[i].delete();
        end
        #1;
        check("t5_rst_v", link.out_v, 0);
        check("t5_rst_rdy", link.in_ready_and, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1 check("t5_rdy", link.in_ready_and, 2'b11);
        mark();
        send(1, hdr(0, 'h900));
        wait_rx(1, "t5_cnt");
        check("t5_data", rx(0), hdr(0, 'h900));
        check("t5_lat", rxc(0), ffc(0) + 3);

        // 10 packets on input 1 for the stats field
        apply_reset();
        mark();
        for (int k = 0; k < 10; k++) begin
            send(1, hdr(k % 2, 'hA00 + k));
            if (k % 2) send(1, 64'hE000 + 64'(k));
        end
        wait_rx(15, "t6_cnt");
        check("t6_first", rx(0), hdr(0, 'hA00));
        check("t6_last", rx(14), 64'hE009);
        check("t6_stats1", link.stats[63:32], stats_en ? 64'd10 : 64'd0);
        check("t6_stats0", link.stats[31:0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_chip_wh_link_concentrator.md
# bsg_chip_wh_link_concentrator

Merges two wormhole ready-and links, the BlackParrot command and response networks, onto one physical ready-and link. It sits between the BlackParrot core complex and a single-link channel-tunnel/IO-complex input, directly upstream of the IO complex. It holds a round-robin lock for the full length of each wormhole packet, so flits from different packets never interleave. Input and output skid buffers give full throughput and a registered output.

## Interface
- `flit_width_p`, default 64: flit width; equals the channel-tunnel payload width.
- `cord_width_p`, default 7: width of the destination cord field at the header LSBs.
- `len_width_p`, default 4: width of the length field at bits `[cord_width_p +: len_width_p]`. Length is the number of body flits after the header.
- `num_in_p`, default 2: number of input links; supported range 2..4.
- `clk_i`, in, 1: the single clock (router clock domain).
- `reset_n_i`, in, 1: reset, asynchronous, active-low.
- `in_v_i`, in, `num_in_p`: per-input flit valid.
- `in_data_i`, in, `num_in_p*flit_width_p`: per-input flit.
- `in_ready_and_o`, out, `num_in_p`: per-input ready; ready-and handshake, transfer on `v & ready`.
- `out_v_o`, out, 1: merged flit valid.
- `out_data_o`, out, `flit_width_p`: merged flit.
- `out_ready_and_i`, in, 1: downstream ready.
- `stats_o`, out, `num_in_p*32`: per-input completed-packet counts. Tied to 0 unless the statistics macro is defined.

## Operation
- Each input enters a 2-entry FIFO. The arbiter sees only FIFO heads. The output is a 2-entry FIFO.
- State machine:
  - IDLE: no owner.
  - LOCKED: owner index plus a remaining-body-flit counter, `len_width_p` bits wide.
- In IDLE:
  - Among inputs whose FIFO head is valid, grant the first one at or after `rr_ptr`, wrapping modulo `num_in_p`.
  - The header moves when the output FIFO has space.
  - If the header len is 0, the packet is complete: stay in IDLE and set `rr_ptr` = grantee+1 (mod `num_in_p`).
  - If the header len is N>0, go to LOCKED with owner = grantee and count = N.
- In LOCKED:
  - Only the owner's FIFO may dequeue. Each body flit moved decrements the count.
  - When the flit moved has count==1, the packet is complete: return to IDLE, set `rr_ptr` = owner+1, and increment the owner's stats counter.
- Header len-0 packets also increment their input's stats counter.
- Non-owner inputs keep filling their FIFOs: `in_ready_and_o[i]` = that FIFO is not full.
- With no valid head, or output FIFO full, nothing moves and state holds.
- Flit contents are never modified. Cord and len are inspected only.

## Timing
- Reset values:
  - `out_v_o` = 0 and `in_ready_and_o` = 0 while `reset_n_i` is low.
  - FIFOs empty, state IDLE, `rr_ptr` = 0, counters 0.
  - `in_ready_and_o` = all 1s from the first rising edge after deassertion.
- Latency: a header accepted at edge t is on `out_v_o` after edge t+2 when the block is idle with an empty output FIFO.
- Throughput: 1 flit per cycle, sustained across back-to-back packets, including a switch of owner in the cycle right after a completion.
- Simultaneous headers in IDLE: the pointer-priority input wins; the loser waits with no flit lost.
- A body flit that is not valid in LOCKED stalls the output with no bubble filled from other inputs.
- `out_ready_and_i` low holds `out_data_o` stable while `out_v_o` is high.
- Reset mid-packet discards partial packets. Downstream is reset in the same reset event.
- Stats counters saturate at 2^32-1.

## Configuration
- `BSG_CHIP_WH_CONCENTRATOR_STATS_EN`:
  - Defined: per-input 32-bit saturating completed-packet counters drive `stats_o`.
  - Undefined: counters are not built and `stats_o` is a constant 0.
  - Arbitration and data paths are identical either way.

## Structure
- The shared package `bsg_chip_pkg` holds:
  - the wormhole header struct (`cord`, `len`, payload remainder), parameterized through the existing `ct_width_gp` and `wh_cord_width_gp`;
  - the state enum `{e_idle, e_locked}`.
- Sub-module: `bsg_chip_wh_lock_arbiter`, the round-robin grant, lock state and length counter. FIFOs reuse the library 2-entry FIFO.

## Test plan
- Single input, header len=3 followed by 3 body flits, output always ready → 4 flits out in order, first at cycle t+2, then 1 per cycle; stats[0]=1.
- Both inputs present len=2 headers in the same cycle after reset → input 0 packet (3 flits) then input 1 packet (3 flits) with no interleave; `rr_ptr` ends at 0.
- Input 0 body flit valid withheld for 5 cycles mid-packet while input 1 has a header waiting → no input-1 flit appears until input 0's last body flit has passed.
- `out_ready_and_i` toggled at random at 50% with 20 len-0 packets on each input → 40 flits out, alternating 0/1, data unchanged, no drop or duplication.
- Assert `reset_n_i` low between body flits 1 and 2 of a len=4 packet → outputs and `in_ready_and_o` go to 0 immediately. After release, a fresh len-0 packet on input 1 passes at t+2 with the block in IDLE.
- Build with and without `BSG_CHIP_WH_CONCENTRATOR_STATS_EN`, 10 packets into input 1 → `stats_o` input-1 field = 10 in the macro build and 0 otherwise; flit output is identical in both builds.
